// File: rtl/feature_frame_loader.sv
// Double-buffered feature frame loader: samples fill one bank while the other is presented
// to the detector; a fresh det_done rise releases the presented frame.
module feature_frame_loader #(
    parameter int unsigned FRAME_LEN = 30,
    parameter int unsigned HI_TGT    = 900,
    parameter int unsigned LO_TGT    = 100
) (
    input  logic                    Clock,
    input  logic                    Rst,
    input  logic [9:0]              sample_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic [1:0]              label_in,
    output logic [FRAME_LEN*10-1:0] frame_out,
    output logic [29:0]             target_out,
    output logic                    start,
    input  logic                    det_done,
    output logic [9:0]              frame_count
);

    localparam int unsigned IdxW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(FRAME_LEN - 1);

    typedef enum logic {PIdle, PStart} state_t;

    state_t          state;
    logic [9:0]      bank_q [2][FRAME_LEN];
    logic [1:0]      label_q [2];
    logic [1:0]      bank_full;
    logic [1:0]      full_d;
    logic            wbank;
    logic            rbank;
    logic [IdxW-1:0] wr_idx;
    logic            det_done_q;
    logic            xfer;
    logic            last_xfer;
    logic            rise;
    logic            release_frame;

    assign sample_ready  = !bank_full[wbank];
    assign xfer          = sample_valid && sample_ready;
    assign last_xfer     = xfer && (wr_idx == LastIdx);
    assign rise          = det_done && !det_done_q;
    assign release_frame = (state == PStart) && rise;

    // Bank storage is never reset; a partial frame is discarded by rewinding wr_idx.
    always_ff @(posedge Clock) begin
        if (xfer) begin
            bank_q[wbank][wr_idx] <= sample_in;
            if (last_xfer) begin
                label_q[wbank] <= label_in;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            wbank  <= 1'b0;
            wr_idx <= '0;
        end else if (xfer) begin
            if (last_xfer) begin
                wbank  <= ~wbank;
                wr_idx <= '0;
            end else begin
                wr_idx <= wr_idx + 1'b1;
            end
        end
    end

    // Fill and release always target different banks, so both updates can land together.
    always_comb begin
        full_d = bank_full;
        if (last_xfer) begin
            full_d[wbank] = 1'b1;
        end
        if (release_frame) begin
            full_d[rbank] = 1'b0;
        end
    end

    always_ff @(posedge Clock) begin
        if (Rst) begin
            state       <= PIdle;
            start       <= 1'b0;
            rbank       <= 1'b0;
            bank_full   <= 2'b00;
            det_done_q  <= 1'b0;
            frame_count <= 10'd0;
        end else begin
            det_done_q <= det_done;
            bank_full  <= full_d;
            case (state)
                PIdle: begin
                    if (bank_full[rbank]) begin
                        state <= PStart;
                        start <= 1'b1;
                    end
                end
                PStart: begin
                    if (rise) begin
                        state       <= PIdle;
                        start       <= 1'b0;
                        rbank       <= ~rbank;
                        frame_count <= frame_count + 10'd1;
                    end
                end
                default: begin
                    state <= PIdle;
                    start <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < FRAME_LEN; i++) begin
            frame_out[i*10 +: 10] = bank_q[rbank][i];
        end
        for (int k = 0; k < 3; k++) begin
            target_out[k*10 +: 10] = (label_q[rbank] == 2'(k)) ? 10'(HI_TGT) : 10'(LO_TGT);
        end
    end

endmodule

// File: tb/tb_feature_frame_loader.sv
// Bench for feature_frame_loader: directed frame table, hand-written corner sequences and a
// randomized run scored against a frame-queue model.
module tb_feature_frame_loader;

    localparam int FL = 30;

    logic            Clock;
    logic            Rst;
    logic [9:0]      sample_in;
    logic            sample_valid;
    logic            sample_ready;
    logic [1:0]      label_in;
    logic [FL*10-1:0] frame_out;
    logic [29:0]     target_out;
    logic            start;
    logic            det_done;
    logic [9:0]      frame_count;

    feature_frame_loader #(.FRAME_LEN(FL), .HI_TGT(900), .LO_TGT(100)) dut (
        .Clock        (Clock),
        .Rst          (Rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .label_in     (label_in),
        .frame_out    (frame_out),
        .target_out   (target_out),
        .start        (start),
        .det_done     (det_done),
        .frame_count  (frame_count)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [9:0]  base;
        logic [1:0]  lab;
        logic [29:0] tgt;
    } vec_t;

    typedef struct packed {
        logic [FL*10-1:0] data;
        logic [1:0]       lab;
    } frm_t;

    int         checks;
    int         errors;
    logic [9:0] exp_count;
    vec_t       vecs[4];
    frm_t       q[$];

    task automatic chk(input string nm, input logic [FL*10-1:0] act, input logic [FL*10-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s bound expired", nm);
    endtask

    // All stimulus is applied and all outputs sampled 1 time unit after the rising edge.
    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    function automatic logic [FL*10-1:0] ramp(input logic [9:0] base);
        logic [FL*10-1:0] r;
        for (int i = 0; i < FL; i++) r[i*10 +: 10] = base + 10'(i);
        return r;
    endfunction

    function automatic logic [29:0] tgt(input logic [1:0] lab);
        logic [29:0] t;
        for (int k = 0; k < 3; k++) t[k*10 +: 10] = (int'(lab) == k) ? 10'd900 : 10'd100;
        return t;
    endfunction

    task automatic push(input logic [9:0] v, input logic [1:0] lab);
        int n;
        n = 0;
        sample_valid = 1'b1;
        sample_in    = v;
        label_in     = lab;
        while (!sample_ready && n < 300) begin
            cyc();
            n++;
        end
        if (n >= 300) fail("push_ready");
        cyc();
        sample_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [9:0] base, input logic [1:0] lab);
        for (int i = 0; i < FL; i++) push(base + 10'(i), (i == FL - 1) ? lab : 2'($urandom));
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!start && n < 50) begin
            cyc();
            n++;
        end
        if (n >= 50) fail("wait_start");
    endtask

    task automatic release_frame();
        det_done = 1'b1;
        cyc();
        det_done = 1'b0;
        exp_count = exp_count + 10'd1;
        chk("start_low_after_release", start, 0);
        chk("frame_count", frame_count, exp_count);
    endtask

    initial begin
        int n;
        int nf;
        int lowrun;
        logic det_prev;
        logic model_ready;
        logic rel;
        logic [FL*10-1:0] part;
        int widx;

        checks = 0;
        errors = 0;
        exp_count = 10'd0;
        Rst = 1'b1;
        sample_valid = 1'b0;
        sample_in = 10'd0;
        label_in = 2'd0;
        det_done = 1'b0;

        vecs[0] = '{10'd1,   2'd1, {10'd100, 10'd900, 10'd100}};
        vecs[1] = '{10'd100, 2'd0, {10'd100, 10'd100, 10'd900}};
        vecs[2] = '{10'd500, 2'd2, {10'd900, 10'd100, 10'd100}};
        vecs[3] = '{10'd994, 2'd3, {10'd100, 10'd100, 10'd100}};

        cyc();
        cyc();
        chk("reset_start", start, 0);
        chk("reset_count", frame_count, 0);
        chk("reset_ready", sample_ready, 1);
        Rst = 1'b0;
        cyc();

        // Directed frame table: latency, contents, targets, release.
        for (int v = 0; v < 4; v++) begin
            send_frame(vecs[v].base, vecs[v].lab);
            chk("start_low_n1", start, 0);
            wait_start(n);
            chk("start_latency", 32'(n), 1);
            chk("frame_first", frame_out[9:0], vecs[v].base);
            chk("frame_last", frame_out[FL*10-1 -: 10], vecs[v].base + 10'(FL - 1));
            chk("frame_all", frame_out, ramp(vecs[v].base));
            chk("targets", target_out, vecs[v].tgt);
            release_frame();
        end

        // A det_done level held into the next frame's start must not release it.
        send_frame(10'd300, 2'd2);
        send_frame(10'd400, 2'd0);
        chk("held_a_start", start, 1);
        chk("held_a_frame", frame_out, ramp(10'd300));
        det_done = 1'b1;
        cyc();
        exp_count = exp_count + 10'd1;
        chk("held_a_released", start, 0);
        chk("held_count", frame_count, exp_count);
        cyc();
        chk("held_b_start", start, 1);
        chk("held_b_frame", frame_out, ramp(10'd400));
        chk("held_b_tgt", target_out, tgt(2'd0));
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("held_level_ignored", start, 1);
            chk("held_level_count", frame_count, exp_count);
        end
        det_done = 1'b0;
        cyc();
        chk("held_drop_start", start, 1);
        release_frame();
        cyc();

        // Backpressure: two full banks hold off sample 61 until one is released.
        for (int i = 1; i <= 60; i++) push(10'(i), 2'd1);
        sample_valid = 1'b1;
        sample_in = 10'd61;
        label_in = 2'd1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready_low", sample_ready, 0);
            chk("bp_start", start, 1);
            chk("bp_frame_stable", frame_out, ramp(10'd1));
            cyc();
        end
        release_frame();
        chk("bp_ready_back", sample_ready, 1);
        cyc();
        sample_valid = 1'b0;
        wait_start(n);
        chk("bp_frame2", frame_out, ramp(10'd31));
        release_frame();
        for (int i = 62; i <= 90; i++) push(10'(i), 2'd1);
        wait_start(n);
        chk("bp_frame3", frame_out, ramp(10'd61));
        release_frame();

        // Reset in the middle of a frame discards it.
        for (int i = 0; i < 17; i++) push(10'(700 + i), 2'd0);
        Rst = 1'b1;
        cyc();
        Rst = 1'b0;
        exp_count = 10'd0;
        chk("midreset_start", start, 0);
        chk("midreset_count", frame_count, 0);
        send_frame(10'd201, 2'd1);
        wait_start(n);
        chk("midreset_latency", 32'(n), 1);
        chk("midreset_frame", frame_out, ramp(10'd201));
        release_frame();

        // Frame counter wrap after 1024 consumed frames.
        nf = 1024 - int'(exp_count);
        for (int f = 0; f < nf; f++) begin
            for (int i = 0; i < FL; i++) push(10'(i), 2'd0);
            wait_start(n);
            release_frame();
        end
        chk("wrap_zero", frame_count, 10'd0);

        // Randomized run against a queue-of-frames model.
        lowrun = 0;
        det_prev = 1'b0;
        widx = 0;
        part = '0;
        for (int c = 0; c < 3000; c++) begin
            sample_valid = (c < 2800) ? 1'($urandom_range(0, 1)) : 1'b0;
            sample_in = 10'($urandom);
            label_in = 2'($urandom);
            det_done = ($urandom_range(0, 2) == 0);
            model_ready = (q.size() < 2);
            chk("rnd_ready", sample_ready, model_ready);
            chk("rnd_count", frame_count, exp_count);
            if (start) begin
                if (q.size() == 0) begin
                    fail("rnd_start_without_frame");
                end else begin
                    chk("rnd_frame", frame_out, q[0].data);
                    chk("rnd_tgt", target_out, tgt(q[0].lab));
                end
            end
            if (q.size() > 0 && !start) lowrun++;
            else lowrun = 0;
            if (lowrun > 1) begin
                fail("rnd_start_latency");
                lowrun = 0;
            end
            rel = start && det_done && !det_prev && (q.size() > 0);
            if (rel) begin
                void'(q.pop_front());
                exp_count = exp_count + 10'd1;
            end
            if (sample_valid && model_ready) begin
                part[widx*10 +: 10] = sample_in;
                widx++;
                if (widx == FL) begin
                    q.push_back('{part, label_in});
                    widx = 0;
                end
            end
            det_prev = det_done;
            cyc();
        end
        det_done = 1'b0;
        cyc();
        if (q.size() != 0) fail("rnd_drain");
        chk("rnd_final_count", frame_count, exp_count);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
